mac_stop_matmul_lanes: RTL and testbench

- Multi-lane successor to the single-product MAC-stop multiplier. Computes C = A x B, with A of size MxK and B of size KxN, read from external synchronous-read matrix memories.
- Produces LANES adjacent C elements per output group and writes each finished group to a result memory port.
- Supports a do_mac stop/resume gate and an unsigned or signed (two's complement) arithmetic mode.
- Sits between the A/B operand RAMs and the result RAM in the matrix accelerator datapath.

---
 rtl/mac_stop_matmul_lanes.sv | 119 +++++++++++
 tb/tb_mac_stop_matmul_lanes.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_stop_matmul_lanes.sv
// mac_stop_matmul_lanes: lane-parallel C = A x B multiplier with a do_mac stop/resume gate
// and unsigned or two's complement arithmetic, fed by synchronous-read operand RAMs.
module mac_stop_matmul_lanes #(
    parameter int M = 4,
    parameter int K = 4,
    parameter int N = 4,
    parameter int LANES = 2,
    parameter int DATA_WIDTH_INIT_MATRIX = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX+$clog2(K),
    parameter int SIGNED_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic do_mac,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0] data_in_a,
    input  logic [LANES*DATA_WIDTH_INIT_MATRIX-1:0] data_in_b,
    output logic matrix_a_re,
    output logic [$clog2(M)-1:0] row_addr_a,
    output logic [$clog2(K)-1:0] col_addr_a,
    output logic matrix_b_re,
    output logic [$clog2(K)-1:0] row_addr_b,
    output logic [$clog2(N)-1:0] col_addr_b,
    output logic result_we,
    output logic [$clog2(M)-1:0] result_row_addr,
    output logic [$clog2(N)-1:0] result_col_addr,
    output logic [LANES*DATA_WIDTH_RESULT_MATRIX-1:0] result_data,
    output logic busy,
    output logic mac_done
);
    localparam int DW = DATA_WIDTH_INIT_MATRIX;
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;
    localparam int MW = $clog2(M);
    localparam int KW = $clog2(K);
    localparam int NW = $clog2(N);
    localparam int G = N / LANES;
    localparam int GW = G > 1 ? $clog2(G) : 1;
    localparam int EXT = RW - 2*DW;
    typedef enum logic [2:0] {IDLE, READ, MULT, ACC, WRITE, DONE} state_t;
    state_t state, state_n;
    logic [MW-1:0] i;
    logic [GW-1:0] j;
    logic [KW-1:0] k;
    logic last_i, last_j, last_k, accept;
    logic [2*DW-1:0] prod_c [LANES];
    logic [2*DW-1:0] prod [LANES];
    logic [RW-1:0] acc [LANES];
    assign last_i = i == MW'(M-1);
    assign last_j = j == GW'(G-1);
    assign last_k = k == KW'(K-1);
    assign accept = start && (state == IDLE || state == DONE);
    // Operands are widened to 2*DW first so one modular multiply covers both signed and unsigned modes.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DW-1:0] b;
        logic [2*DW-1:0] ax, bx;
        assign b = data_in_b[l*DW +: DW];
        assign ax = {{DW{SIGNED_MODE != 0 && data_in_a[DW-1]}}, data_in_a};
        assign bx = {{DW{SIGNED_MODE != 0 && b[DW-1]}}, b};
        assign prod_c[l] = ax * bx;
        assign result_data[l*RW +: RW] = acc[l];
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? READ : IDLE;
            READ:    state_n = do_mac ? MULT : READ;
            MULT:    state_n = ACC;
            ACC:     state_n = last_k ? WRITE : READ;
            WRITE:   state_n = (last_i && last_j) ? DONE : READ;
            DONE:    state_n = start ? READ : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i <= '0;
            j <= '0;
            k <= '0;
            for (int l = 0; l < LANES; l++) begin
                prod[l] <= '0;
                acc[l] <= '0;
            end
        end else begin
            state <= state_n;
            if (accept) begin
                i <= '0;
                j <= '0;
                k <= '0;
                for (int l = 0; l < LANES; l++) acc[l] <= '0;
            end
            if (state == MULT) begin
                for (int l = 0; l < LANES; l++) prod[l] <= prod_c[l];
            end
            if (state == ACC) begin
                for (int l = 0; l < LANES; l++)
                    acc[l] <= acc[l] + {{EXT{SIGNED_MODE != 0 && prod[l][2*DW-1]}}, prod[l]};
                k <= k + 1'b1;
            end
            if (state == WRITE) begin
                k <= '0;
                for (int l = 0; l < LANES; l++) acc[l] <= '0;
                j <= last_j ? '0 : j + 1'b1;
                if (last_j) i <= last_i ? '0 : i + 1'b1;
            end
        end
    end
    assign matrix_a_re = state == READ && do_mac;
    assign matrix_b_re = state == READ && do_mac;
    assign row_addr_a = i;
    assign col_addr_a = k;
    assign row_addr_b = k;
    assign col_addr_b = NW'(int'(j) * LANES);
    assign result_we = state == WRITE;
    assign result_row_addr = i;
    assign result_col_addr = NW'(int'(j) * LANES);
    assign busy = state == READ || state == MULT || state == ACC || state == WRITE;
    assign mac_done = state == DONE;
endmodule

// File: tb/tb_mac_stop_matmul_lanes.sv
// tb_mac_stop_matmul_lanes: directed checks of write order, values, latency, stall, reset and restart.
module tb_mac_stop_matmul_lanes;
    localparam int DW = 32;
    localparam int RW = 66;
    localparam int L = 2;
    logic clk = 0, reset = 1, start = 0, do_mac = 1, s_start = 0;
    logic [DW-1:0] data_in_a = '0, s_da = '0;
    logic [L*DW-1:0] data_in_b = '0, s_db = '0;
    logic matrix_a_re, matrix_b_re, result_we, busy, mac_done;
    logic [1:0] row_addr_a, col_addr_a, row_addr_b, col_addr_b, result_row_addr, result_col_addr;
    logic [L*RW-1:0] result_data;
    logic s_a_re, s_b_re, s_we, s_busy, s_done;
    logic [1:0] s_ra, s_ca, s_rb, s_cb, s_rr, s_rc;
    logic [L*RW-1:0] s_rd;
    logic [DW-1:0] am [4][4];
    logic [DW-1:0] bm [4][4];
    typedef struct {int row; int col; logic [2*RW-1:0] data;} cap_t;
    typedef struct {int row; int col; logic [RW-1:0] c0; logic [RW-1:0] c1;} vec_t;
    cap_t q[$], sq[$];
    vec_t exp_tab [8];
    int errs = 0, checks = 0;

    mac_stop_matmul_lanes dut (
        .clk(clk), .reset(reset), .start(start), .do_mac(do_mac),
        .data_in_a(data_in_a), .data_in_b(data_in_b),
        .matrix_a_re(matrix_a_re), .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
        .matrix_b_re(matrix_b_re), .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
        .result_we(result_we), .result_row_addr(result_row_addr), .result_col_addr(result_col_addr),
        .result_data(result_data), .busy(busy), .mac_done(mac_done)
    );

    mac_stop_matmul_lanes #(.SIGNED_MODE(1)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .do_mac(do_mac),
        .data_in_a(s_da), .data_in_b(s_db),
        .matrix_a_re(s_a_re), .row_addr_a(s_ra), .col_addr_a(s_ca),
        .matrix_b_re(s_b_re), .row_addr_b(s_rb), .col_addr_b(s_cb),
        .result_we(s_we), .result_row_addr(s_rr), .result_col_addr(s_rc),
        .result_data(s_rd), .busy(s_busy), .mac_done(s_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (matrix_a_re) data_in_a <= am[row_addr_a][col_addr_a];
        if (matrix_b_re) data_in_b <= {bm[row_addr_b][col_addr_b+1], bm[row_addr_b][col_addr_b]};
        if (s_a_re) s_da <= 32'hFFFF_FFFD;
        if (s_b_re) s_db <= {2{32'd2}};
    end

    always @(negedge clk) begin
        if (result_we) q.push_back('{int'(result_row_addr), int'(result_col_addr), result_data});
        if (s_we) sq.push_back('{int'(s_rr), int'(s_rc), s_rd});
    end

    task automatic check(input string name, input logic [2*RW-1:0] act, input logic [2*RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag, input bit sel, input int exp_cyc);
        int cyc = 0;
        while (!(sel ? s_done : mac_done) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " cycles"}, cyc, exp_cyc);
    endtask

    task automatic check_writes(input string tag, input cap_t qq[$], input bit use_tab, input logic [RW-1:0] cv);
        check({tag, " count"}, qq.size(), 8);
        for (int n = 0; n < 8 && n < qq.size(); n++) begin
            check($sformatf("%s w%0d addr", tag, n), qq[n].row*16 + qq[n].col,
                  use_tab ? exp_tab[n].row*16 + exp_tab[n].col : (n/2)*16 + (n%2)*2);
            check($sformatf("%s w%0d data", tag, n), qq[n].data,
                  use_tab ? {exp_tab[n].c1, exp_tab[n].c0} : {cv, cv});
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, " ctl"}, {busy, mac_done, matrix_a_re, matrix_b_re, result_we}, 0);
        check({tag, " addr"}, {row_addr_a, col_addr_a, row_addr_b, col_addr_b, result_row_addr, result_col_addr}, 0);
        check({tag, " data"}, result_data, 0);
    endtask

    task automatic load(input bit ones);
        logic [DW-1:0] a_t [4][4];
        logic [DW-1:0] b_t [4][4];
        a_t = '{'{6,2,5,2}, '{6,2,6,1}, '{2,4,5,2}, '{7,2,5,1}};
        b_t = '{'{1,1,4,4}, '{1,7,2,1}, '{3,2,1,1}, '{2,1,6,6}};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                am[r][c] = ones ? 32'hFFFF_FFFF : a_t[r][c];
                bm[r][c] = ones ? 32'hFFFF_FFFF : b_t[r][c];
            end
    endtask

    task automatic stall_seq();
        int t = 0;
        logic [7:0] held;
        while (!(matrix_a_re && row_addr_a == 1) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("stall row1 read seen", t < 1000, 1);
        held = {row_addr_a, col_addr_a, row_addr_b, col_addr_b};
        do_mac = 0;
        for (int c = 0; c < 7; c++) begin
            #1;
            check($sformatf("stall re %0d", c), {matrix_a_re, matrix_b_re}, 0);
            check($sformatf("stall addr %0d", c), {row_addr_a, col_addr_a, row_addr_b, col_addr_b}, held);
            @(negedge clk);
        end
        do_mac = 1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_tab[0] = '{0, 0, 27, 32};
        exp_tab[1] = '{0, 2, 45, 43};
        exp_tab[2] = '{1, 0, 28, 33};
        exp_tab[3] = '{1, 2, 40, 38};
        exp_tab[4] = '{2, 0, 25, 42};
        exp_tab[5] = '{2, 2, 33, 29};
        exp_tab[6] = '{3, 0, 26, 32};
        exp_tab[7] = '{3, 2, 43, 41};
        load(0);
        repeat (3) @(negedge clk);
        check_idle_outs("reset");
        reset = 0;
        // plain run
        q.delete();
        pulse_start();
        check("busy after start", {busy, mac_done}, 2'b10);
        wait_done("basic", 0, 104);
        check_writes("basic", q, 1, '0);
        // do_mac stall during row 1, started from DONE
        q.delete();
        pulse_start();
        check("restart clears done", {busy, mac_done}, 2'b10);
        fork
            wait_done("stall", 0, 111);
            stall_seq();
        join
        check_writes("stall", q, 1, '0);
        // start while busy is ignored
        q.delete();
        pulse_start();
        fork
            wait_done("busy start", 0, 104);
            begin
                repeat (20) @(negedge clk);
                start = 1;
                @(negedge clk);
                start = 0;
            end
        join
        check_writes("busy start", q, 1, '0);
        // reset mid-run
        q.delete();
        pulse_start();
        repeat (39) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_idle_outs("mid reset");
        reset = 0;
        q.delete();
        repeat (60) @(negedge clk);
        check("writes after reset", q.size(), 0);
        check("idle after reset", {busy, mac_done}, 0);
        pulse_start();
        wait_done("post reset", 0, 104);
        check_writes("post reset", q, 1, '0);
        // full-scale unsigned
        load(1);
        q.delete();
        pulse_start();
        wait_done("ones", 0, 104);
        check_writes("ones", q, 0, 66'h3_FFFF_FFF8_0000_0004);
        // signed instance
        sq.delete();
        @(negedge clk);
        s_start = 1;
        @(negedge clk);
        s_start = 0;
        wait_done("signed", 1, 104);
        check_writes("signed", sq, 0, 66'h3_FFFF_FFFF_FFFF_FFE8);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
